// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline encodings and datapath sizes used by the execute stage.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: add/sub/and/or/slt; unlisted opcodes produce zero.
module alu #(
  parameter int W = riscv_pkg::XLEN
) (
  input  logic [W-1:0] SrcA,
  input  logic [W-1:0] SrcB,
  input  logic [2:0]   ALUControl,
  output logic [W-1:0] Result,
  output logic         Zero
);
  import riscv_pkg::*;

  logic lt_s;

  assign lt_s = ($signed(SrcA) < $signed(SrcB));

  // operation select; add/sub wrap naturally at W bits
  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_SLT: Result = {{(W-1){1'b0}}, lt_s};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register feeding the memory stage.
module execute_cycle #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  MemWriteE,
  input  logic                  JumpE,
  input  logic                  BranchE,
  input  logic [2:0]            ALUControlE,
  input  logic                  ALUSrcE,
  input  logic [XLEN-1:0]       RD1E,
  input  logic [XLEN-1:0]       RD2E,
  input  logic [XLEN-1:0]       PCE,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [XLEN-1:0]       Imm_ExtE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [XLEN-1:0]       ResultW,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic                  RegWriteM,
  output logic [1:0]            ResultSrcM,
  output logic                  MemWriteM,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [REG_ADDR_W-1:0] RdM,
  output logic [XLEN-1:0]       PCPlus4M
);
  import riscv_pkg::*;

  logic [XLEN-1:0] src_a_s;
  logic [XLEN-1:0] fwd_b_s;
  logic [XLEN-1:0] src_b_s;
  logic [XLEN-1:0] alu_result_s;
  logic            zero_s;

  // SrcA forwarding; the MEM path reads the EX/MEM flop, so no comb loop
  always_comb begin
    src_a_s = RD1E;
    case (ForwardAE)
      FWD_WB:  src_a_s = ResultW;
      FWD_MEM: src_a_s = ALUResultM;
      default: src_a_s = RD1E;
    endcase
  end

  // rs2 forwarding; this value is also the store data regardless of ALUSrcE
  always_comb begin
    fwd_b_s = RD2E;
    case (ForwardBE)
      FWD_WB:  fwd_b_s = ResultW;
      FWD_MEM: fwd_b_s = ALUResultM;
      default: fwd_b_s = RD2E;
    endcase
  end

  assign src_b_s = ALUSrcE ? Imm_ExtE : fwd_b_s;

  alu #(.W(XLEN)) u_alu (
    .SrcA       (src_a_s),
    .SrcB       (src_b_s),
    .ALUControl (ALUControlE),
    .Result     (alu_result_s),
    .Zero       (zero_s)
  );

  assign PCTargetE = PCE + Imm_ExtE;
  assign PCSrcE    = (BranchE & zero_s) | JumpE;

  // EX/MEM register: no stall; bubbles arrive as zeroed control from upstream
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      ALUResultM <= alu_result_s;
      WriteDataM <= fwd_b_s;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline. Consumes the ID/EX bundle driven by the decode stage.
- Applies operand forwarding from MEM and WB, runs the ALU, and resolves branch/jump redirect and target.
- Registers the EX/MEM bundle consumed by the memory stage; ALUResultM also serves as the MEM forwarding source.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- RegWriteE  in  1  register write enable from decode
- ResultSrcE  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4
- MemWriteE  in  1  store enable
- JumpE  in  1  jal
- BranchE  in  1  beq
- ALUControlE  in  3  ALU operation
- ALUSrcE  in  1  0 = forwarded rs2, 1 = immediate
- RD1E  in  XLEN  rs1 data
- RD2E  in  XLEN  rs2 data
- PCE  in  XLEN  instruction PC
- RdE  in  REG_ADDR_W  destination register
- Imm_ExtE  in  XLEN  extended immediate
- PCPlus4E  in  XLEN  PC+4
- ForwardAE  in  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
- ForwardBE  in  2  rs2 select, same encoding as ForwardAE
- ResultW  in  XLEN  writeback value
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  XLEN  branch/jump target (combinational)
- RegWriteM  out  1  registered RegWriteE
- ResultSrcM  out  2  registered ResultSrcE
- MemWriteM  out  1  registered MemWriteE
- ALUResultM  out  XLEN  registered ALU result
- WriteDataM  out  XLEN  registered forwarded rs2 (store data)
- RdM  out  REG_ADDR_W  registered RdE
- PCPlus4M  out  XLEN  registered PCPlus4E

Behaviour:
- Forward muxes:
  - SrcAE = mux(ForwardAE); code 11 selects RD1E.
  - FwdBE = mux(ForwardBE); code 11 selects RD2E.
  - SrcBE = ALUSrcE ? Imm_ExtE : FwdBE.
  - WriteDataE = FwdBE always, independent of ALUSrcE.
- ALU ops:
  - 000 add.
  - 001 sub.
  - 010 and.
  - 011 or.
  - 101 slt: signed compare, result 1 or 0 zero-extended to XLEN.
  - Any other code gives result 0.
- ALU arithmetic: add/sub wrap modulo 2^XLEN, with no overflow trap.
- ZeroE = (ALU result == 0).
- PCTargetE = PCE + Imm_ExtE, wrapping.
- PCSrcE = (BranchE & ZeroE) | JumpE.
- PCSrcE and PCTargetE are combinational, valid in the same cycle as their inputs, with zero latency.
- EX/MEM register:
  - One-cycle latency; all seven M outputs update on every posedge clk.
  - No enable and no stall input. Flush/bubble insertion belongs to the hazard unit upstream, which zeroes the ID/EX control inputs.
- Reset: when rst=1 at posedge, every registered output goes to 0: RegWriteM=0, ResultSrcM=00, MemWriteM=0, ALUResultM=0, WriteDataM=0, RdM=0, PCPlus4M=0.
  - Reset takes priority over data the same cycle.
  - A reset mid-stream discards the in-flight instruction; the first non-reset edge captures the current E inputs.
- Simultaneous forwarding: encodings are mutually exclusive per operand. ForwardAE and ForwardBE may select different sources in the same cycle.
- Forward-from-M uses the registered ALUResultM, i.e. the previous instruction's result. No combinational loop exists: ALUResultM comes from a flop.
- JumpE with BranchE=0 forces PCSrcE=1 regardless of ZeroE. The ALU still computes, and RegWriteM carries the jal writeback via ResultSrcM=10.
- x0 handling is not performed here: RdM=0 with RegWriteM=1 is passed through unchanged.

Decomposition:
- Shared package riscv_pkg:
  - ALU control encodings: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - Forward select encodings: FWD_RF=00, FWD_WB=01, FWD_MEM=10.
  - ResultSrc encodings: RES_ALU, RES_MEM, RES_PC4.
  - XLEN constant.
- One sub-module: alu (inputs SrcA, SrcB, ALUControl; outputs Result, Zero), purely combinational. Forwarding muxes, the target adder and the EX/MEM register stay in execute_cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with nonzero inputs -> all M outputs 0. Release with RD1E=5, RD2E=7, ALUControlE=000, ALUSrcE=0 -> next edge ALUResultM=12, WriteDataM=7.
- Sub/slt: RD1E=3, RD2E=0xFFFFFFFF, ALUControlE=101 -> ALUResultM=0 (3 < -1 false). ALUControlE=001 -> ALUResultM=4.
- Branch: BranchE=1, RD1E=RD2E=0x20, ALUControlE=001, PCE=0x100, Imm_ExtE=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0xF8 same cycle. With RD2E=0x21 -> PCSrcE=0.
- Forwarding: cycle N computes 10+20 (ALUResultM=30 next). Cycle N+1 sets ForwardAE=10, RD1E=0, RD2E=1, add -> ALUResultM=31. Then ForwardBE=01, ResultW=0x55, ALUSrcE=0, MemWriteE=1 -> WriteDataM=0x55, MemWriteM=1.
- Immediate vs store data: ALUSrcE=1, Imm_ExtE=8, RD1E=0x1000, RD2E=0xAB -> ALUResultM=0x1008, WriteDataM=0xAB.
- Jump: JumpE=1, ResultSrcE=10, PCE=0x40, Imm_ExtE=0x10, PCPlus4E=0x44, RdE=1 -> PCSrcE=1, PCTargetE=0x50. Next edge PCPlus4M=0x44, RdM=1, ResultSrcM=10.
